// File: rtl/serial_deserializer.sv
// serial_deserializer: serial-in / parallel-out capture stage.
//
// Takes a registered serial bit stream (MSB first) and assembles WIDTH-bit words. A frame begins
// with a start pulse in IDLE. Bits are taken only on cycles where sin_en is high. The completed
// word appears on pout together with a one-cycle pout_valid pulse. frame_cnt counts completed
// frames and wraps.
//
// Optional feature (macro SERIAL_DESER_PARITY_CHECK_EN):
//   When the macro is defined, the frame carries one extra even-parity bit after the data.
//   pout and parity_err are loaded only when that bit is sampled.
//   When the macro is undefined, parity_err is tied to 0.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   sin        in   serial data bit, MSB first
//   sin_en     in   bit-valid strobe
//   start      in   begin a frame (honoured only in IDLE)
//   ovr_clr    in   synchronous clear of the overrun flag
//   pout       out  last completed word
//   pout_valid out  one-cycle pulse when pout updates
//   ready      out  high in IDLE
//   bit_cnt    out  data bits captured in the current frame
//   frame_cnt  out  completed frames, wraps
//   overrun    out  sticky: start seen while busy
//   parity_err out  parity result of the last frame
module serial_deserializer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8,
    localparam int unsigned BCW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             start,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    output logic             ready,
    output logic [BCW-1:0]   bit_cnt,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             overrun,
    output logic             parity_err
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StParity,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] shift_word;
    logic             last_bit;

`ifdef SERIAL_DESER_PARITY_CHECK_EN
    logic parity_err_q, parity_err_d;
`endif

    assign shift_word = {shreg_q[WIDTH-2:0], sin};
    assign last_bit   = (bit_cnt_q == BCW'(WIDTH - 1));

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        pout_d      = pout_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
`ifdef SERIAL_DESER_PARITY_CHECK_EN
        parity_err_d = parity_err_q;
`endif

        // Set wins over clear. A start outside IDLE is never queued.
        if (start && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StShift;
                    shreg_d   = '0;
                    bit_cnt_d = '0;
                end
            end
            StShift: begin
                if (sin_en) begin
                    shreg_d   = shift_word;
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (last_bit) begin
`ifdef SERIAL_DESER_PARITY_CHECK_EN
                        state_d = StParity;
`else
                        state_d = StDone;
                        pout_d  = shift_word;
`endif
                    end
                end
            end
`ifdef SERIAL_DESER_PARITY_CHECK_EN
            StParity: begin
                if (sin_en) begin
                    state_d      = StDone;
                    pout_d       = shreg_q;
                    parity_err_d = (^shreg_q) ^ sin;
                end
            end
`endif
            StDone: begin
                state_d     = StIdle;
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            pout_q      <= '0;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            pout_q      <= pout_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef SERIAL_DESER_PARITY_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign pout       = pout_q;
    assign pout_valid = (state_q == StDone);
    assign ready      = (state_q == StIdle);
    assign bit_cnt    = bit_cnt_q;
    assign frame_cnt  = frame_cnt_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer (WIDTH=8, CNT_W=2 so frame_cnt wraps quickly).
// Expected words are queued when a frame is driven and checked when pout_valid pulses.
module tb_serial_deserializer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             sin;
    logic             sin_en;
    logic             start;
    logic             ovr_clr;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             ready;
    logic [3:0]       bit_cnt;
    logic [CNT_W-1:0] frame_cnt;
    logic             overrun;
    logic             parity_err;

    typedef struct packed {
        logic [WIDTH-1:0] word;
        logic             perr;
    } exp_t;

    exp_t sb_q[$];
    int   checks;
    int   failures;
    int   exp_frames;

    serial_deserializer #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_en    (sin_en),
        .start     (start),
        .ovr_clr   (ovr_clr),
        .pout      (pout),
        .pout_valid(pout_valid),
        .ready     (ready),
        .bit_cnt   (bit_cnt),
        .frame_cnt (frame_cnt),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: runs mid-cycle on the valid pulse.
    always @(negedge clk) begin
        if (rst && pout_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 32'(pout_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("pout", 32'(pout), 32'(e.word));
                check("parity_err", 32'(parity_err), 32'(e.perr));
                check("frame_cnt_in_done", 32'(frame_cnt), 32'(exp_frames));
                exp_frames = (exp_frames + 1) % (1 << CNT_W);
            end
        end
    end

    // Drives one full frame. gap_max>0 inserts 1..gap_max idle cycles before each bit.
    // ovr_at>=0 pulses start (and optionally ovr_clr) together with that bit.
    task automatic send_frame(input logic [WIDTH-1:0] w, input int gap_max, input int ovr_at,
                              input logic clr_too, input logic par_bit);
        exp_t e;
        e.word = w;
`ifdef SERIAL_DESER_PARITY_CHECK_EN
        e.perr = (^w) ^ par_bit;
`else
        e.perr = 1'b0;
`endif
        sb_q.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ready_busy", 32'(ready), 32'd0);
        check("bit_cnt_start", 32'(bit_cnt), 32'd0);
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (gap_max > 0) begin
                int n;
                n = $urandom_range(1, gap_max);
                for (int g = 0; g < n; g++) tick();
                check("bit_cnt_gap", 32'(bit_cnt), 32'(i));
            end
            sin    = w[WIDTH-1-i];
            sin_en = 1'b1;
            if (i == ovr_at) begin
                start   = 1'b1;
                ovr_clr = clr_too;
            end
            tick();
            sin_en  = 1'b0;
            start   = 1'b0;
            ovr_clr = 1'b0;
        end
        check("bit_cnt_full", 32'(bit_cnt), 32'(WIDTH));
`ifdef SERIAL_DESER_PARITY_CHECK_EN
        // Held in PARITY: no valid until the parity bit is sampled.
        tick();
        check("no_valid_before_parity", 32'(pout_valid), 32'd0);
        sin    = par_bit;
        sin_en = 1'b1;
        tick();
        sin_en = 1'b0;
`else
        if (par_bit) begin
            // parity bit unused without the feature
        end
`endif
        check("valid_pulse", 32'(pout_valid), 32'd1);
        check("ready_done", 32'(ready), 32'd0);
        tick();
        check("valid_one_cycle", 32'(pout_valid), 32'd0);
        check("ready_after", 32'(ready), 32'd1);
        check("frame_cnt_after", 32'(frame_cnt), 32'(exp_frames));
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        exp_frames = 0;
        rst        = 1'b1;
        sin        = 1'b0;
        sin_en     = 1'b0;
        start      = 1'b0;
        ovr_clr    = 1'b0;

        // Asynchronous reset, checked before any clock edge.
        #2 rst = 1'b0;
        #1;
        check("rst_pout", 32'(pout), 32'd0);
        check("rst_valid", 32'(pout_valid), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_bit_cnt", 32'(bit_cnt), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Basic frame, then a stalled frame.
        send_frame(8'hB2, 0, -1, 1'b0, 1'b0);
        check("frame_cnt_1", 32'(frame_cnt), 32'd1);
        send_frame(8'h5A, 3, -1, 1'b0, 1'b0);
        check("frame_cnt_2", 32'(frame_cnt), 32'd2);
        check("no_overrun", 32'(overrun), 32'd0);

        // Overrun during a frame; frame still completes.
        send_frame(8'hC3, 0, 3, 1'b0, 1'b0);
        check("overrun_set", 32'(overrun), 32'd1);
        check("frame_cnt_3", 32'(frame_cnt), 32'd3);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("overrun_clr", 32'(overrun), 32'd0);

        // Set wins over clear; also the wrap to 0.
        send_frame(8'hA5, 0, 2, 1'b1, 1'b1);
        check("overrun_set_wins", 32'(overrun), 32'd1);
        check("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;

        // Abort mid-frame by reset: nothing reaches pout.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sin    = 1'b1;
            sin_en = 1'b1;
            tick();
        end
        sin_en = 1'b0;
        check("abort_bit_cnt", 32'(bit_cnt), 32'd4);
        rst = 1'b0;
        #1;
        exp_frames = 0;
        check("abort_pout", 32'(pout), 32'd0);
        check("abort_valid", 32'(pout_valid), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_bit_cnt_rst", 32'(bit_cnt), 32'd0);
        check("abort_frame_cnt", 32'(frame_cnt), 32'd0);
        check("abort_overrun", 32'(overrun), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("abort_pout_held", 32'(pout), 32'd0);
        check("abort_ready_idle", 32'(ready), 32'd1);
        send_frame(8'hFF, 0, -1, 1'b0, 1'b0);
        check("frame_cnt_post_abort", 32'(frame_cnt), 32'd1);
        check("pout_held_ff", 32'(pout), 32'hFF);

`ifdef SERIAL_DESER_PARITY_CHECK_EN
        send_frame(8'hB2, 0, -1, 1'b0, 1'b0);
        check("parity_ok", 32'(parity_err), 32'd0);
        send_frame(8'hB2, 0, -1, 1'b0, 1'b1);
        check("parity_bad", 32'(parity_err), 32'd1);
`endif

        tick();
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
